// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared FSM state, arbitration modes and I/O region selector
// for the byte-serialising memory port controller. No ports.
package mem_port_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // mem_a[17:16] value that selects the I/O region
    localparam logic [1:0] IO_SEL = 2'b11;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: combinational grant over req, fixed or round-robin.
// Ports: clk, rst, rdy, req, accept -> gnt_vld, gnt_idx.
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter  int N_PORTS  = 2,
    parameter  int ARB_MODE = ARB_FIXED,
    localparam int IW       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic [N_PORTS-1:0] req,
    input  logic               accept,
    output logic               gnt_vld,
    output logic [IW-1:0]      gnt_idx
);

    logic [IW-1:0] ptr;
    logic [IW:0]   j;

    always_comb begin
        gnt_vld = |req;
        gnt_idx = '0;
        j       = '0;
        if (ARB_MODE == ARB_RR) begin
            // scan ptr+N down to ptr+1 so the closest requester wins
            for (int i = N_PORTS; i >= 1; i--) begin
                j = {1'b0, ptr} + (IW+1)'(i);
                if (j >= (IW+1)'(N_PORTS)) begin
                    j = j - (IW+1)'(N_PORTS);
                end
                if (req[j[IW-1:0]]) begin
                    gnt_idx = j[IW-1:0];
                end
            end
        end else begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt_idx = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IW'(N_PORTS - 1);
        end else if (rdy && accept && gnt_vld) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: arbitrates N requesters onto one byte-wide memory bus.
// Ports: clk/rst/rdy, per-port req/we/addr/len/wdata -> done, rdata, busy; mem_din/dout/a/wr.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter  int N_PORTS   = 2,
    parameter  int MAX_BYTES = 4,
    parameter  int ADDR_W    = 32,
    parameter  int ARB_MODE  = ARB_FIXED,
    localparam int LEN_W     = $clog2(MAX_BYTES) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic [N_PORTS-1:0]             req,
    input  logic [N_PORTS-1:0]             we,
    input  logic [N_PORTS*ADDR_W-1:0]      addr,
    input  logic [N_PORTS*LEN_W-1:0]       len,
    input  logic [N_PORTS*MAX_BYTES*8-1:0] wdata,
    output logic [N_PORTS-1:0]             done,
    output logic [MAX_BYTES*8-1:0]         rdata,
    output logic                           busy,
    input  logic [7:0]                     mem_din,
    output logic [7:0]                     mem_dout,
    output logic [ADDR_W-1:0]              mem_a,
    output logic                           mem_wr
);

    localparam int DW = MAX_BYTES * 8;
    localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    // counts up to MAX_BYTES+1 read cycles
    localparam int CW = LEN_W + 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   port_q, port_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CW-1:0]   n_q, n_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   wsh_q, wsh_d;
    logic [DW-1:0]   acc_q, acc_d;

    logic [N_PORTS-1:0] done_d;
    logic [DW-1:0]      rdata_d;
    logic               busy_d;
    logic [7:0]         dout_d;
    logic [ADDR_W-1:0]  mem_a_d;
    logic               wr_d;

    logic              gnt_vld;
    logic [IW-1:0]     gnt_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic [DW-1:0]     sel_wdata;
    logic [CW-1:0]     sel_n;
    logic [CW-1:0]     len_ext;
    logic [DW-1:0]     merge;

    mem_port_arbiter #(
        .N_PORTS  (N_PORTS),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .req     (req),
        .accept  (state_q == IDLE),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (gnt_idx == IW'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_len   = len[i*LEN_W +: LEN_W];
                sel_wdata = wdata[i*DW +: DW];
            end
        end
    end

    assign len_ext = CW'(sel_len);

    always_comb begin
        if (len_ext == '0) begin
            sel_n = CW'(1);
        end else if (len_ext > CW'(MAX_BYTES)) begin
            sel_n = CW'(MAX_BYTES);
        end else begin
            sel_n = len_ext;
        end
    end

    // byte addressed at cycle k is on mem_din two counts later
    always_comb begin
        merge = acc_q;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (cnt_q == CW'(k + 2)) begin
                merge[8*k +: 8] = mem_din;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        base_d  = base_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        wsh_d   = wsh_q;
        acc_d   = acc_q;
        done_d  = '0;
        rdata_d = rdata;
        busy_d  = busy;
        dout_d  = mem_dout;
        mem_a_d = mem_a;
        wr_d    = mem_wr;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    port_d  = gnt_idx;
                    base_d  = sel_addr;
                    n_d     = sel_n;
                    cnt_d   = CW'(1);
                    acc_d   = '0;
                    mem_a_d = sel_addr;
                    busy_d  = 1'b1;
                    wr_d    = sel_we;
                    dout_d  = sel_we ? sel_wdata[7:0] : 8'h00;
                    wsh_d   = sel_wdata >> 8;
                    state_d = sel_we ? WR : RD;
                end
            end
            RD: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = merge;
                if (cnt_q < n_q) begin
                    mem_a_d = base_q + ADDR_W'(cnt_q);
                end else begin
                    mem_a_d = '0;
                end
                if (cnt_q == n_q + CW'(1)) begin
                    for (int i = 0; i < N_PORTS; i++) begin
                        if (port_q == IW'(i)) begin
                            done_d[i] = 1'b1;
                        end
                    end
                    rdata_d = merge;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            WR: begin
                if (cnt_q < n_q) begin
                    mem_a_d = base_q + ADDR_W'(cnt_q);
                    dout_d  = wsh_q[7:0];
                    wsh_d   = wsh_q >> 8;
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    for (int i = 0; i < N_PORTS; i++) begin
                        if (port_q == IW'(i)) begin
                            done_d[i] = 1'b1;
                        end
                    end
                    wr_d    = 1'b0;
                    mem_a_d = '0;
                    dout_d  = 8'h00;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            port_q   <= '0;
            base_q   <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            wsh_q    <= '0;
            acc_q    <= '0;
            done     <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            mem_dout <= 8'h00;
            mem_a    <= '0;
            mem_wr   <= 1'b0;
        end else if (rdy) begin
            state_q  <= state_d;
            port_q   <= port_d;
            base_q   <= base_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            wsh_q    <= wsh_d;
            acc_q    <= acc_d;
            done     <= done_d;
            rdata    <= rdata_d;
            busy     <= busy_d;
            mem_dout <= dout_d;
            mem_a    <= mem_a_d;
            mem_wr   <= wr_d;
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed plus random transactions against a
// transaction-level model of the memory port controller.
module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        init_mem = 1'b1;

    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [95:0] addr = '0;
    logic [8:0]  len = '0;
    logic [95:0] wdata = '0;
    logic [2:0]  done;
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [1:0]  req_b = '0;
    logic [1:0]  we_b = '0;
    logic [63:0] addr_b = '0;
    logic [5:0]  len_b = '0;
    logic [63:0] wdata_b = '0;
    logic [1:0]  done_b;
    logic [31:0] rdata_b;
    logic        busy_b;
    logic [7:0]  mem_din_b;
    logic [7:0]  mem_dout_b;
    logic [31:0] mem_a_b;
    logic        mem_wr_b;

    logic [7:0]  bus_mem [4096];
    logic [7:0]  ref_mem [4096];
    logic [31:0] last_rdata;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    mem_port_ctrl #(
        .N_PORTS(3), .MAX_BYTES(4), .ADDR_W(32), .ARB_MODE(1)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req(req), .we(we),
        .addr(addr), .len(len), .wdata(wdata), .done(done),
        .rdata(rdata), .busy(busy), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    mem_port_ctrl #(
        .N_PORTS(2), .MAX_BYTES(4), .ADDR_W(32), .ARB_MODE(0)
    ) dut_fp (
        .clk(clk), .rst(rst), .rdy(rdy), .req(req_b), .we(we_b),
        .addr(addr_b), .len(len_b), .wdata(wdata_b), .done(done_b),
        .rdata(rdata_b), .busy(busy_b), .mem_din(mem_din_b),
        .mem_dout(mem_dout_b), .mem_a(mem_a_b), .mem_wr(mem_wr_b)
    );

    function automatic logic [7:0] dflt(input logic [11:0] i);
        return i[7:0] ^ {i[11:8], i[3:0]} ^ 8'h5A;
    endfunction

    // byte memory with one-cycle registered read, frozen while rdy is low
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 4096; i++) bus_mem[i] <= dflt(12'(i));
            bus_mem[12'h100] <= 8'h11;
            bus_mem[12'h101] <= 8'h22;
            bus_mem[12'h102] <= 8'h33;
            bus_mem[12'h103] <= 8'h44;
        end else if (rdy) begin
            if (mem_wr) bus_mem[mem_a[11:0]] <= mem_dout;
            mem_din <= bus_mem[mem_a[11:0]];
        end
    end

    always @(posedge clk) begin
        if (rdy) mem_din_b <= mem_a_b[7:0] ^ 8'hC3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input int c, input int n, input int last,
                           input bit w, input logic [31:0] a,
                           input logic [31:0] d, input int p,
                           input logic [31:0] er);
        logic [31:0] ea;
        logic [31:0] sh;
        logic [2:0]  ed;
        ed = (c == last) ? 3'(1 << p) : 3'b000;
        if (c <= n) begin
            ea = a + 32'(c - 1);
            sh = d >> (8 * (c - 1));
            chk("bus_addr", mem_a, ea);
            chk("bus_wr", mem_wr, w);
            if (w) chk("bus_wdata", mem_dout, sh[7:0]);
        end else begin
            chk("bus_addr_off", mem_a, 0);
            chk("bus_wr_off", mem_wr, 0);
            if (w) chk("bus_wdata_off", mem_dout, 0);
        end
        chk("done", done, ed);
        chk("busy", busy, c != last);
        if (c == last) chk("rdata", rdata, w ? last_rdata : er);
    endtask

    // one transaction; call from a cycle where the DUT is idle or in done
    task automatic xact(input int p, input bit w, input logic [31:0] a,
                        input int ln, input logic [31:0] d,
                        input int st_at, input int st_len, input bit hold);
        int n, last, c;
        logic [31:0] er, t;
        n = (ln == 0) ? 1 : ln;
        last = w ? n + 1 : n + 2;
        er = '0;
        for (int k = 0; k < n; k++) begin
            t = a + 32'(k);
            if (w) ref_mem[t[11:0]] = d[8*k +: 8];
            else   er[8*k +: 8] = ref_mem[t[11:0]];
        end
        req[p] = 1'b1;
        we[p] = w;
        addr[p*32 +: 32] = a;
        len[p*3 +: 3] = 3'(ln);
        wdata[p*32 +: 32] = d;
        c = 0;
        while (c < last) begin
            if (c == st_at && st_len > 0) begin
                rdy = 1'b0;
                repeat (st_len) begin
                    tick();
                    chk_cyc(c, n, last, w, a, d, p, er);
                end
                rdy = 1'b1;
            end
            tick();
            c++;
            if (c == 1) begin
                if (!hold) req[p] = 1'b0;
                addr[p*32 +: 32] = $urandom;
                wdata[p*32 +: 32] = $urandom;
            end
            chk_cyc(c, n, last, w, a, d, p, er);
        end
        req[p] = 1'b0;
        if (!w) last_rdata = er;
    endtask

    initial begin
        int cur, ptr, n0, p, ln, n, last, st_at, st_len;
        bit w, hold;
        logic [31:0] a, d;

        for (int i = 0; i < 4096; i++) ref_mem[i] = dflt(12'(i));
        ref_mem[12'h100] = 8'h11;
        ref_mem[12'h101] = 8'h22;
        ref_mem[12'h102] = 8'h33;
        ref_mem[12'h103] = 8'h44;
        last_rdata = '0;

        tick();
        tick();
        init_mem = 1'b0;
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_mem_wr", mem_wr, 0);
        rst = 1'b0;
        tick();

        xact(0, 1'b0, 32'h0000_0100, 4, 0, 0, 0, 1'b1);
        chk("plan_read", last_rdata, 32'h4433_2211);
        xact(1, 1'b1, 32'h0003_0000, 2, 32'h0000_BEEF, 0, 0, 1'b1);
        xact(2, 1'b0, 32'h0000_0100, 4, 0, 2, 3, 1'b0);
        xact(0, 1'b0, 32'h0003_0000, 2, 0, 0, 0, 1'b0);
        chk("readback_write", last_rdata, 32'h0000_BEEF);
        xact(1, 1'b0, 32'h0000_0555, 0, 0, 0, 0, 1'b1);
        xact(2, 1'b0, 32'hFFFF_FFFF, 2, 0, 1, 2, 1'b1);
        tick();

        // reset in the middle of a 4-byte write, after its second byte
        req[0] = 1'b1;
        we[0] = 1'b1;
        addr[31:0] = 32'h0000_0200;
        len[2:0] = 3'd4;
        wdata[31:0] = 32'hA1B2_C3D4;
        tick();
        tick();
        chk("abort_byte2_addr", mem_a, 32'h0000_0201);
        rst = 1'b1;
        req[0] = 1'b0;
        tick();
        ref_mem[12'h200] = 8'hD4;
        ref_mem[12'h201] = 8'hC3;
        last_rdata = '0;
        chk("abort_mem_wr", mem_wr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_mem_a", mem_a, 0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("abort_no_done", done, 0);
            chk("abort_idle_wr", mem_wr, 0);
        end

        // round-robin contention, all three ports asking continuously
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0;
            addr[i*32 +: 32] = 32'h0000_0400 + 32'(i);
            len[i*3 +: 3] = 3'd1;
        end
        req = 3'b111;
        ptr = 2;
        cur = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c % 3 == 1) begin
                for (int i = 3; i >= 1; i--) begin
                    if (req[(ptr + i) % 3]) cur = (ptr + i) % 3;
                end
                ptr = cur;
            end
            tick();
            if (c % 3 == 1) chk("rr_addr", mem_a, 32'h400 + 32'(cur));
            chk("rr_done", done, (c % 3 == 0) ? 3'(1 << cur) : 3'b000);
            if (c % 3 == 0) begin
                chk("rr_rdata", rdata, {24'h0, ref_mem[12'h400 + 12'(cur)]});
                last_rdata = {24'h0, ref_mem[12'h400 + 12'(cur)]};
            end
        end
        chk("rr_fourth_is_port0", cur, 0);
        req = 3'b000;
        tick();
        chk("rr_end_done", done, 0);
        chk("rr_end_busy", busy, 0);

        xact(1, 1'b0, 32'h0000_0200, 4, 0, 0, 0, 1'b1);

        // fixed priority: port 0 wins while it keeps asking
        addr_b = {32'h0000_0020, 32'h0000_0010};
        len_b = {3'd1, 3'd1};
        req_b = 2'b11;
        n0 = 0;
        cur = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c % 3 == 1) cur = req_b[0] ? 0 : 1;
            tick();
            chk("fp_done", done_b, (c % 3 == 0) ? 2'(1 << cur) : 2'b00);
            chk("fp_mem_wr", mem_wr_b, 0);
            if (c % 3 == 0) begin
                chk("fp_rdata", rdata_b,
                    {24'h0, (cur == 0 ? 8'h10 : 8'h20) ^ 8'hC3});
                if (cur == 0) begin
                    n0++;
                    if (n0 == 3) req_b[0] = 1'b0;
                end else begin
                    req_b[1] = 1'b0;
                end
            end
        end
        chk("fp_port0_count", n0, 3);
        tick();
        chk("fp_end_busy", busy_b, 0);

        for (int it = 0; it < 60; it++) begin
            p = $urandom_range(0, 2);
            w = 1'($urandom_range(0, 1));
            ln = $urandom_range(0, 4);
            d = $urandom;
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                2: a = {14'h0, 2'b11, 16'($urandom)};
                default: a = 32'h100 + 32'($urandom_range(0, 15));
            endcase
            n = (ln == 0) ? 1 : ln;
            last = w ? n + 1 : n + 2;
            st_len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            st_at = $urandom_range(1, last - 1);
            hold = 1'($urandom_range(0, 1));
            xact(p, w, a, ln, d, st_at, st_len, hold);
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("gap_done", done, 0);
                chk("gap_busy", busy, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Parametrised memory-port controller between N requesters (e.g. instruction fetch, load/store, line fill) and the single byte-wide memory bus of the cpu top.
- Arbitrates among requesters (fixed-priority or round-robin).
- Serialises each 1..MAX_BYTES little-endian access into byte transfers with pipelined reads (2-cycle latency) and 1-cycle writes.
- Returns assembled data with a one-cycle done pulse, and freezes completely while rdy is low.

Parameters:
- N_PORTS, 2, number of requester ports (1..8); port 0 has highest fixed priority.
- MAX_BYTES, 4, largest access in bytes; power of two, 1..16.
- ADDR_W, 32, address width on requester side and on mem_a.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin starting after the last granted port.
- LEN_W (localparam), $clog2(MAX_BYTES)+1, width of the per-port length field.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low = pause, no state changes
- req  in  N_PORTS  per-port request; held high until that port's done
- we  in  N_PORTS  per-port write enable (1 = write)
- addr  in  N_PORTS*ADDR_W  per-port start byte address, flattened, port i at [i*ADDR_W +: ADDR_W]
- len  in  N_PORTS*LEN_W  per-port byte count 1..MAX_BYTES; 0 treated as 1
- wdata  in  N_PORTS*MAX_BYTES*8  per-port write data, byte k at bits [8k+7:8k]
- done  out  N_PORTS  one-cycle pulse to the served port
- rdata  out  MAX_BYTES*8  read data, valid in the done cycle and held until the next read completes; bytes beyond len are zero
- busy  out  1  high while a transaction is in flight
- mem_din  in  8  memory read data
- mem_dout  out  8  memory write data
- mem_a  out  ADDR_W  memory byte address
- mem_wr  out  1  1 = write

Behaviour:
- All outputs registered.
- Reset values: done=0, rdata=0, busy=0, mem_a=0, mem_dout=0, mem_wr=0, round-robin pointer=N_PORTS-1, state IDLE.
- Reset has priority over rdy.
- rdy low at an edge: that edge is ignored entirely; outputs hold.
- All cycle counts below are counted in rdy-high edges.
- States:
  - IDLE: if any req is high, the arbiter picks port p. Latch p, we, addr, len and wdata. Drive mem_a=addr and mem_wr=we; if writing, drive mem_dout=wdata[7:0]. Go to RD or WR. busy=1.
  - RD: mem_a steps +1 per cycle over len bytes, then returns to 0. The byte addressed in cycle k is valid on mem_din in cycle k+1 and is sampled at edge k+2 into rdata lane (k-first). After the last sample, done[p]=1 for one cycle; go to IDLE.
  - WR: one byte per cycle with mem_wr=1. After the last byte, mem_wr=0, mem_a=0, mem_dout=0, done[p]=1; go to IDLE.
- Timing, with the request sampled at edge 0:
  - Read of n bytes: addresses in cycles 1..n; done in cycle n+2.
  - Write of n bytes: bytes in cycles 1..n; done in cycle n+1.
- Back-to-back: a request is sampled in the IDLE cycle that coincides with the previous done, so there is exactly one bus-idle cycle between transactions.
- Address wrap: addr+k wraps modulo 2^ADDR_W.
- I/O region (mem_a[17:16]==2'b11): each byte is addressed exactly once per transaction, with no speculative or repeated reads. A stall holds mem_a, so the memory sees no new address.
- Requester changes: changes to req, addr or wdata after the grant are ignored. Dropping req mid-transaction does not abort it; done still pulses.
- Simultaneous requests:
  - ARB_MODE 0: lowest index wins.
  - ARB_MODE 1: first requesting index after the pointer, cyclically; the pointer updates to p on grant.
- Reset mid-transaction: abort; the next cycle has mem_wr=0, mem_a=0, done=0. A partial write is not completed.

Decomposition:
- Package mem_port_pkg holds:
  - state enum (IDLE, RD, WR);
  - arbitration mode constants ARB_FIXED=0 and ARB_RR=1;
  - IO_SEL=2'b11 constant for address bits [17:16].
- One sub-module, mem_port_arbiter: parametrised N_PORTS/ARB_MODE, combinational grant plus registered round-robin pointer, advanced only on an accepted grant with rdy=1.

Test Plan:
- Single read: port0 requests a 4-byte read at 0x100, memory holds 0x11,0x22,0x33,0x44 -> mem_a = 0x100..0x103 in cycles 1..4; done[0] in cycle 6; rdata=0x44332211.
- Single write: port1 requests a 2-byte write at 0x30000 with wdata 0x0000BEEF -> mem_wr=1 with (0x30000, 0xEF) then (0x30001, 0xBE); done[1] in cycle 3; mem_wr=0 after.
- Contention, ARB_MODE=1, N_PORTS=3: all ports request 1-byte reads continuously -> grants 0,1,2,0; one idle bus cycle between transactions.
- Contention, ARB_MODE=0: ports 0 and 1 both request -> port 0 is served first, and again ahead of port 1 while it keeps requesting.
- rdy stall: drop rdy for 3 cycles mid-way through a 4-byte read -> mem_a/mem_wr frozen; done arrives exactly 3 cycles later; rdata correct.
- Edge cases:
  - rst asserted during a 4-byte write after byte 2 -> next cycle mem_wr=0, busy=0, no done.
  - len=0 -> treated as a 1-byte access.
  - Read at 0xFFFFFFFF with len 2 -> second address is 0x00000000.
